// File: rtl/encoder_pkg.sv
// Shared types and helpers for the 4:2 round-robin request encoder.
// Holds the index width, the FSM encoding and small bit-vector helpers.
package encoder_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input idx_t idx);
    logic [NUM_REQ-1:0] mask;
    mask      = 4'b0000;
    mask[idx] = 1'b1;
    return mask;
  endfunction

  function automatic logic [2:0] popcount4(input logic [NUM_REQ-1:0] vec);
    return {2'b00, vec[0]} + {2'b00, vec[1]} + {2'b00, vec[2]} + {2'b00, vec[3]};
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational circular priority search over a 4-bit vector.
// Returns the first set index at or after start_i, wrapping past index 3.
module rr_pick_4
  import encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  idx_t cand_s;

  // Walk farthest-first so the nearest set candidate is the last one written.
  always_comb begin
    idx_o   = start_i;
    found_o = 1'b0;
    cand_s  = start_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = start_i + idx_t'(k);
      if (vec_i[cand_s]) begin
        idx_o   = cand_s;
        found_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/encoder_4_2_rr.sv
// Pending-request encoder: collects 4 request pulses, emits one index at a time
// through a valid/ready output stage, and counts requests lost to a full slot.
module encoder_4_2_rr
  import encoder_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req_in,
  output logic [1:0]        enc_out,
  output logic              enc_valid,
  input  logic              enc_ready,
  output logic [3:0]        pend_out,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  pend_q, pend_d;
  idx_t                enc_q, enc_d;
  idx_t                last_grant_q, last_grant_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  idx_t                start_s;
  idx_t                pick_idx_s;
  logic                pick_found_s;
  logic                load_s;
  logic [NUM_REQ-1:0]  xfer_mask_s;
  logic [NUM_REQ-1:0]  lost_s;
  logic [2:0]          lost_cnt_s;
  logic [DROP_W:0]     drop_sum_s;

  // Search origin: one past the last grant in round-robin mode, else index 0.
  always_comb begin
    if (RR_EN) begin
      start_s = last_grant_q + idx_t'(1'b1);
    end else begin
      start_s = idx_t'(1'b0);
    end
  end

  rr_pick_4 u_pick (
    .vec_i   (pend_q),
    .start_i (start_s),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // Output-stage FSM: decide whether the picked index moves into enc_out.
  always_comb begin
    state_d      = state_q;
    load_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          load_s  = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (enc_ready) begin
          if (pick_found_s) begin
            load_s  = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output code, grant pointer and pending update; a bit re-requested while
  // being transferred stays pending rather than being counted as lost.
  always_comb begin
    if (load_s) begin
      enc_d        = pick_idx_s;
      last_grant_d = pick_idx_s;
      xfer_mask_s  = idx_onehot(pick_idx_s);
    end else begin
      enc_d        = enc_q;
      last_grant_d = last_grant_q;
      xfer_mask_s  = 4'b0000;
    end
    pend_d     = (pend_q & ~xfer_mask_s) | req_in;
    lost_s     = req_in & pend_q & ~xfer_mask_s;
    lost_cnt_s = popcount4(lost_s);
  end

  // Saturating drop counter and sticky overflow flag.
  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_q} + (DROP_W + 1)'(lost_cnt_s);
    if (drop_sum_s[DROP_W]) begin
      drop_cnt_d = {DROP_W{1'b1}};
    end else begin
      drop_cnt_d = drop_sum_s[DROP_W-1:0];
    end
    overflow_d = overflow_q | (|lost_s);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= 4'b0000;
      enc_q        <= 2'd0;
      last_grant_q <= 2'd3;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= {DROP_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      enc_q        <= enc_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign enc_out   = enc_q;
  assign enc_valid = (state_q == HOLD);
  assign pend_out  = pend_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_encoder_4_2_rr.sv
// Directed bench for encoder_4_2_rr: a round-robin instance and a fixed-priority
// instance share clock and reset; expected values are hand-computed per step.
module tb_encoder_4_2_rr;

  logic       clk;
  logic       rst_n;

  logic [3:0] req_a, req_b;
  logic       rdy_a, rdy_b;
  logic [1:0] enc_a, enc_b;
  logic       val_a, val_b;
  logic [3:0] pend_a, pend_b;
  logic       ovf_a, ovf_b;
  logic [7:0] drop_a, drop_b;

  int n_cmp = 0;
  int n_mis = 0;

  encoder_4_2_rr #(.RR_EN(1'b1), .DROP_W(8)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_a), .enc_out(enc_a), .enc_valid(val_a),
    .enc_ready(rdy_a), .pend_out(pend_a), .overflow(ovf_a), .drop_cnt(drop_a)
  );

  encoder_4_2_rr #(.RR_EN(1'b0), .DROP_W(8)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req_in(req_b), .enc_out(enc_b), .enc_valid(val_b),
    .enc_ready(rdy_b), .pend_out(pend_b), .overflow(ovf_b), .drop_cnt(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 4'b0000; rdy_a = 1'b0;
    req_b = 4'b0000; rdy_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 4'b0000; rdy_a = 1'b0;
    req_b = 4'b0000; rdy_b = 1'b0;
    #2;
    check("rst_valid", val_a, 1'b0);
    check("rst_enc", enc_a, 2'd0);
    check("rst_pend", pend_a, 4'b0000);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_drop", drop_a, 8'd0);
    do_reset();

    // Single request: valid two edges after the request, for one cycle.
    req_a = 4'b0100; rdy_a = 1'b1;
    tick();
    check("lat_e1_valid", val_a, 1'b0);
    check("lat_e1_pend", pend_a, 4'b0100);
    req_a = 4'b0000;
    tick();
    check("lat_e2_valid", val_a, 1'b1);
    check("lat_e2_enc", enc_a, 2'd2);
    tick();
    check("lat_e3_valid", val_a, 1'b0);
    check("lat_e3_pend", pend_a, 4'b0000);

    // Round-robin drain of all four requests, back to back.
    do_reset();
    req_a = 4'b1111; rdy_a = 1'b1;
    tick();
    check("rr_load_pend", pend_a, 4'b1111);
    req_a = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_seq_valid", val_a, 1'b1);
      check("rr_seq_enc", enc_a, i);
    end
    tick();
    check("rr_end_valid", val_a, 1'b0);
    check("rr_end_pend", pend_a, 4'b0000);

    // Fixed priority with index 0 re-requested every cycle starves the rest.
    rdy_a = 1'b0;
    req_b = 4'b1111; rdy_b = 1'b1;
    tick();
    req_b = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fx_valid", val_b, 1'b1);
      check("fx_enc", enc_b, 2'd0);
      check("fx_pend", pend_b, 4'b1111);
    end
    check("fx_drop", drop_b, 8'd0);
    req_b = 4'b0000; rdy_b = 1'b0;

    // Stall in HOLD with enc_out=1; a second request for bit 1 is lost.
    do_reset();
    req_a = 4'b0010; rdy_a = 1'b0;
    tick();
    req_a = 4'b0000;
    tick();
    check("st_enc", enc_a, 2'd1);
    check("st_valid", val_a, 1'b1);
    check("st_pend0", pend_a, 4'b0000);
    req_a = 4'b0010;
    tick();
    check("st_pend1", pend_a, 4'b0010);
    check("st_drop0", drop_a, 8'd0);
    req_a = 4'b0000;
    tick();
    req_a = 4'b0010;
    tick();
    check("st_pend2", pend_a, 4'b0010);
    check("st_ovf", ovf_a, 1'b1);
    check("st_drop1", drop_a, 8'd1);
    check("st_enc_stable", enc_a, 2'd1);
    check("st_valid_stable", val_a, 1'b1);

    // Multiple losses in one cycle add together.
    req_a = 4'b1010;
    tick();
    check("ml_drop2", drop_a, 8'd2);
    check("ml_pend", pend_a, 4'b1010);
    tick();
    check("ml_drop4", drop_a, 8'd4);

    // Saturation after 300 further losses.
    req_a = 4'b0010;
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    check("sat_drop", drop_a, 8'd255);
    check("sat_ovf", ovf_a, 1'b1);
    check("sat_enc", enc_a, 2'd1);
    check("sat_valid", val_a, 1'b1);

    // Asynchronous reset mid-HOLD clears everything before the next edge.
    req_a = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", val_a, 1'b0);
    check("ar_enc", enc_a, 2'd0);
    check("ar_pend", pend_a, 4'b0000);
    check("ar_ovf", ovf_a, 1'b0);
    check("ar_drop", drop_a, 8'd0);
    tick();
    rst_n = 1'b1;
    rdy_a = 1'b1;
    tick();
    check("post_rst_valid", val_a, 1'b0);
    check("post_rst_pend", pend_a, 4'b0000);

    // Re-request of bit 2 in its transfer cycle stays pending, no drop.
    do_reset();
    req_a = 4'b0100; rdy_a = 1'b1;
    tick();
    tick();
    check("rx_enc", enc_a, 2'd2);
    check("rx_valid", val_a, 1'b1);
    check("rx_pend", pend_a, 4'b0100);
    check("rx_drop", drop_a, 8'd0);
    check("rx_ovf", ovf_a, 1'b0);
    req_a = 4'b0000;
    tick();
    check("rx2_enc", enc_a, 2'd2);
    check("rx2_valid", val_a, 1'b1);
    check("rx2_pend", pend_a, 4'b0000);
    tick();
    check("rx3_valid", val_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/encoder_4_2_rr.md
ENCODER_4_2_RR -- requirements
Module: encoder_4_2_rr

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin priority; 0 = fixed priority with index 0 highest.
REQ-002 Parameter: DROP_W, 8, width of saturating dropped-request counter.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_in  input  4  request pulses, bit i = request for code i.
REQ-006 enc_out  output  2  encoded index of granted request.
REQ-007 enc_valid  output  1  enc_out holds a valid code.
REQ-008 enc_ready  input  1  consumer accepts enc_out this cycle.
REQ-009 pend_out  output  4  current pending-request register.
REQ-010 overflow  output  1  sticky flag, a request was lost.
REQ-011 drop_cnt  output  DROP_W  saturating count of lost requests.

Function
REQ-012 Pending register SHALL update each cycle: pend <= (pend & ~xfer_mask) | req_in, where xfer_mask is one-hot of the index moved to the output stage this cycle (0 if none).
REQ-013 FSM SHALL have two states: IDLE (enc_valid=0) and HOLD (enc_valid=1).
REQ-014 IDLE: if pend != 0, SHALL load the selected index into enc_out, clear its pend bit, go HOLD; else stay IDLE.
REQ-015 HOLD, enc_ready=0: enc_out and enc_valid SHALL remain stable.
REQ-016 HOLD, enc_ready=1: if pend != 0, SHALL load the next selected index (back-to-back, no bubble) and stay HOLD; else go IDLE.
REQ-017 Selection SHALL use registered pend only, never req_in of the same cycle; latency req_in edge to enc_valid = 2 cycles when idle.
REQ-018 RR_EN=1: search SHALL start at (last_grant+1) mod 4 and wrap; last_grant updates on every load into the output stage.
REQ-019 RR_EN=0: lowest set index of pend SHALL be selected.
REQ-020 A request is lost when req_in[i]=1, pend[i]=1 and bit i is not transferred that cycle; each lost bit SHALL set overflow and increment drop_cnt by one (multiple losses in one cycle add their count).
REQ-021 drop_cnt SHALL saturate at all-ones; no wrap.
REQ-022 req_in[i]=1 in the cycle bit i is transferred SHALL leave pend[i]=1 and SHALL NOT count as lost.
REQ-023 A request for index i while enc_out=i is held in HOLD SHALL be pended normally, not merged.
REQ-024 enc_ready while IDLE SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force: pend=0, enc_out=0, enc_valid=0, state=IDLE, last_grant=3, overflow=0, drop_cnt=0.
REQ-026 Reset asserted mid-HOLD SHALL discard the held code and all pending requests; no handshake completes.
REQ-027 First cycle after rst_n release SHALL behave as IDLE with empty pend.

Structure
REQ-028 Shared package encoder_pkg SHALL hold NUM_REQ=4, IDX_W=2, idx_t typedef and state enum (IDLE, HOLD).
REQ-029 Priority search SHALL be a combinational sub-module rr_pick_4 (inputs: 4-bit vector, 2-bit start index; outputs: 2-bit index, found flag), instantiated once.
REQ-030 No other hierarchy; all flops in encoder_4_2_rr.

Verification
REQ-031 Reset, then req_in=4'b0100 one cycle, enc_ready=1 -> enc_valid=1 with enc_out=2 exactly 2 cycles later, one cycle only, pend_out=0 afterward.
REQ-032 RR_EN=1, pend=4'b1111 loaded, enc_ready=1 constant -> enc_out sequence 0,1,2,3 on consecutive cycles, no bubble, then IDLE.
REQ-033 RR_EN=0, same stimulus with fresh req_in=4'b0001 each cycle -> enc_out stays 0 every grant (starvation of 1-3 by design).
REQ-034 enc_ready=0 in HOLD with enc_out=1; req_in=4'b0010 twice on separate cycles -> pend_out=4'b0010, overflow=1, drop_cnt=1; enc_out stable throughout.
REQ-035 Force 300 lost requests (DROP_W=8) -> drop_cnt=255, overflow=1; rst_n low mid-HOLD -> all outputs zero within same cycle, state IDLE.
REQ-036 req_in[2]=1 in the cycle bit 2 is transferred -> pend_out[2]=1 next cycle, drop_cnt unchanged.
